// File: rtl/llc_access_scheduler.sv
// Snoop-priority request scheduler in front of the LLC lookup engine; one operation in flight at a time.
// Optional grant statistics counters are enabled by defining LLC_SCHED_STATS_EN.
module llc_access_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_valid,
  output logic              proc_ready,
  input  logic [1:0]        proc_cmd,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              eng_valid,
  output logic [2:0]        eng_cmd,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_done,
`ifdef LLC_SCHED_STATS_EN
  output logic [15:0]       proc_grant_cnt,
  output logic [15:0]       snp_grant_cnt,
  output logic [15:0]       starve_cnt,
`endif
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] LP_STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SW-1:0]       r_streak;
  logic                r_op_src;
  logic [1:0]          r_op_cmd;
  logic [ADDR_W-1:0]   r_op_addr;
  logic                w_starved;
  logic                w_grant_snp;
  logic                w_grant_proc;

  // The streak never exceeds its maximum, so "not starved" means streak < STARVE_MAX.
  assign w_starved    = (r_streak == LP_STREAK_MAX);
  assign w_grant_snp  = snp_valid && (!proc_valid || !w_starved);
  assign w_grant_proc = proc_valid && !w_grant_snp;

  always_comb begin
    w_state_next = r_state;
    proc_ready   = 1'b0;
    snp_ready    = 1'b0;
    eng_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        // Readys stay low while reset is asserted even though the state is IDLE.
        if (!rst) begin
          proc_ready = w_grant_proc;
          snp_ready  = w_grant_snp;
          if (proc_valid || snp_valid) w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        eng_valid    = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (eng_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak  <= '0;
      r_op_src  <= 1'b0;
      r_op_cmd  <= 2'd0;
      r_op_addr <= '0;
    end else if (proc_ready) begin
      r_streak  <= '0;
      r_op_src  <= 1'b0;
      r_op_cmd  <= proc_cmd;
      r_op_addr <= proc_addr;
    end else if (snp_ready) begin
      if (!proc_valid)     r_streak <= '0;
      else if (!w_starved) r_streak <= r_streak + 1'b1;
      r_op_src  <= 1'b1;
      r_op_cmd  <= snp_cmd;
      r_op_addr <= snp_addr;
    end
  end

  assign eng_cmd  = {r_op_src, r_op_cmd};
  assign eng_addr = r_op_addr;
  assign busy     = (r_state != IDLE);

`ifdef LLC_SCHED_STATS_EN
  logic [15:0] r_proc_grant_cnt;
  logic [15:0] r_snp_grant_cnt;
  logic [15:0] r_starve_cnt;

  // A processor grant while a snoop is also waiting can only be a forced one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proc_grant_cnt <= '0;
      r_snp_grant_cnt  <= '0;
      r_starve_cnt     <= '0;
    end else begin
      if (proc_ready)              r_proc_grant_cnt <= r_proc_grant_cnt + 16'd1;
      if (snp_ready)               r_snp_grant_cnt  <= r_snp_grant_cnt + 16'd1;
      if (proc_ready && snp_valid) r_starve_cnt     <= r_starve_cnt + 16'd1;
    end
  end

  assign proc_grant_cnt = r_proc_grant_cnt;
  assign snp_grant_cnt  = r_snp_grant_cnt;
  assign starve_cnt     = r_starve_cnt;
`endif

endmodule

// File: tb/tb_llc_access_scheduler.sv
// Randomized bench for llc_access_scheduler against a cycle-timestamp transaction model.
// Also exercises the grant counters when LLC_SCHED_STATS_EN is defined.
module tb_llc_access_scheduler;
  localparam int AW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          proc_valid, proc_ready, snp_valid, snp_ready;
  logic [1:0]    proc_cmd, snp_cmd;
  logic [AW-1:0] proc_addr, snp_addr, eng_addr;
  logic          eng_valid, eng_done, busy;
  logic [2:0]    eng_cmd;
`ifdef LLC_SCHED_STATS_EN
  logic [15:0]   proc_grant_cnt, snp_grant_cnt, starve_cnt;
`endif

  llc_access_scheduler #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .proc_valid(proc_valid), .proc_ready(proc_ready), .proc_cmd(proc_cmd), .proc_addr(proc_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .eng_valid(eng_valid), .eng_cmd(eng_cmd), .eng_addr(eng_addr), .eng_done(eng_done),
`ifdef LLC_SCHED_STATS_EN
    .proc_grant_cnt(proc_grant_cnt), .snp_grant_cnt(snp_grant_cnt), .starve_cnt(starve_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: the scheduler is free from cycle free_at on; an accept at cycle N
  // issues at N+1, and the bench returns done at some chosen cycle >= N+2.
  int cyc = 0, free_at = 0, issue_at = -10, done_at = -10, streak = 0;
  bit op_src = 1'b0, op_seen = 1'b0;
  logic [1:0]    op_cmd = 2'd0;
  logic [AW-1:0] op_addr = '0;
  int m_pg = 0, m_sg = 0, m_st = 0;
  int p_pct = 0, s_pct = 0, done_min = 1, done_max = 1, spur_pct = 0;
  bit drop_p = 1'b0, drop_s = 1'b0;
  bit inj_p = 1'b0, inj_s = 1'b0;
  logic [1:0]    inj_cmd = 2'd0;
  logic [AW-1:0] inj_addr = '0;
  string order = "";

  task automatic run_cycle(input bit do_rst);
    bit idle, g_s, g_p;
    @(negedge clk);
    rst = do_rst;
    if (drop_p) begin proc_valid = 1'b0; drop_p = 1'b0; end
    if (drop_s) begin snp_valid = 1'b0; drop_s = 1'b0; end
    if (!proc_valid && $urandom_range(99) < p_pct) begin
      proc_valid = 1'b1; proc_cmd = 2'($urandom_range(3)); proc_addr = $urandom;
    end
    if (!snp_valid && $urandom_range(99) < s_pct) begin
      snp_valid = 1'b1; snp_cmd = 2'($urandom_range(3)); snp_addr = $urandom;
    end
    if (inj_p) begin proc_valid = 1'b1; proc_cmd = inj_cmd; proc_addr = inj_addr; inj_p = 1'b0; end
    if (inj_s) begin snp_valid = 1'b1; snp_cmd = inj_cmd; snp_addr = inj_addr; inj_s = 1'b0; end
    idle = (cyc >= free_at);
    if (!idle && cyc == done_at)     eng_done = 1'b1;
    else if (!idle && cyc > issue_at) eng_done = 1'b0;
    else                              eng_done = ($urandom_range(99) < spur_pct);
    g_s = snp_valid && (!proc_valid || streak < SM);
    g_p = proc_valid && !g_s;
    if (do_rst || !idle) begin g_s = 1'b0; g_p = 1'b0; end
    #1;
    check_value("proc_ready", proc_ready, g_p);
    check_value("snp_ready", snp_ready, g_s);
    check_value("eng_valid", eng_valid, cyc == issue_at);
    check_value("busy", busy, !idle);
    if (!idle || !op_seen) begin
      check_value("eng_cmd", eng_cmd, {op_src, op_cmd});
      check_value("eng_addr", eng_addr, op_addr);
    end
    if (do_rst) begin
      free_at = cyc + 1; issue_at = -10; done_at = -10; streak = 0;
      op_src = 1'b0; op_cmd = 2'd0; op_addr = '0; op_seen = 1'b0;
      m_pg = 0; m_sg = 0; m_st = 0;
    end else if (g_s || g_p) begin
      op_seen = 1'b1;
      op_src  = g_s;
      op_cmd  = g_s ? snp_cmd : proc_cmd;
      op_addr = g_s ? snp_addr : proc_addr;
      if (g_p) begin
        streak = 0; m_pg++;
        if (snp_valid) m_st++;
        drop_p = 1'b1; order = {order, "P"};
      end else begin
        streak = proc_valid ? ((streak + 1 > SM) ? SM : streak + 1) : 0;
        m_sg++; drop_s = 1'b1; order = {order, "S"};
      end
      issue_at = cyc + 1;
      done_at  = cyc + 1 + $urandom_range(done_max, done_min);
      free_at  = done_at + 1;
    end
    cyc++;
  endtask

  task automatic check_stats(input string tag);
`ifdef LLC_SCHED_STATS_EN
    check_value({tag, "_proc_grant_cnt"}, proc_grant_cnt, m_pg);
    check_value({tag, "_snp_grant_cnt"}, snp_grant_cnt, m_sg);
    check_value({tag, "_starve_cnt"}, starve_cnt, m_st);
`else
    check_value({tag, "_grants"}, m_pg + m_sg, m_pg + m_sg);
`endif
  endtask

  initial begin
    rst = 1'b1; proc_valid = 1'b1; snp_valid = 1'b1; eng_done = 1'b0;
    proc_cmd = 2'd0; snp_cmd = 2'd0; proc_addr = '0; snp_addr = '0;

    // Reset with both valids high, then the continuous-contention starvation run.
    p_pct = 100; s_pct = 100; done_min = 1; done_max = 1;
    run_cycle(1'b1);
    run_cycle(1'b1);
    order = "";
    for (int i = 0; i < 200 && order.len() < 10; i++) run_cycle(1'b0);
    check_value("starve_order", order == "SSSSPSSSSP", 1'b1);
    $display("starvation order %s", order);
`ifdef LLC_SCHED_STATS_EN
    check_value("stats_snp_8", snp_grant_cnt, 16'd8);
    check_value("stats_proc_2", proc_grant_cnt, 16'd2);
    check_value("stats_starve_2", starve_cnt, 16'd2);
`endif

    // Drain, then a single processor write with a long engine latency.
    p_pct = 0; s_pct = 0; done_min = 2; done_max = 6; spur_pct = 50;
    for (int i = 0; i < 30; i++) run_cycle(1'b0);
    inj_p = 1'b1; inj_cmd = 2'd1; inj_addr = 32'h0040_1000;
    for (int i = 0; i < 12; i++) run_cycle(1'b0);
    $display("proc write op addr %08h cmd %0d", op_addr, op_cmd);

    // Reset while waiting on the engine, with a snoop waiting to go next.
    done_min = 10; done_max = 10; spur_pct = 0;
    inj_s = 1'b1; inj_cmd = 2'd3; inj_addr = 32'hdead_beef;
    for (int i = 0; i < 4; i++) run_cycle(1'b0);
    s_pct = 100; done_min = 1; done_max = 3;
    run_cycle(1'b1);
    for (int i = 0; i < 6; i++) run_cycle(1'b0);
    $display("post-reset op src %0d addr %08h", op_src, op_addr);

    // Randomized traffic with occasional resets and spurious done pulses.
    p_pct = 40; s_pct = 40; done_min = 1; done_max = 6; spur_pct = 30;
    for (int i = 0; i < 3000; i++) run_cycle($urandom_range(99) < 2);
    check_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
